// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces the push button and the
// 3-bit switch bank before they reach the holiday-lights controller.
// Produces a press strobe, a debounced level, and an optional long-press
// strobe. Also produces a stable switch vector with a change strobe.
// Optional feature macro: INPUT_COND_LONG_PRESS_EN (builds hcnt/long_done and
// the button_long strobe; when undefined button_long is tied low).
module input_conditioner #(
  parameter logic [31:0] DEBOUNCE_CYCLES   = 32'd1000000,
  parameter logic [31:0] LONG_PRESS_CYCLES = 32'd100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  input  logic [2:0] switch_raw,
  output logic       button_pulse,
  output logic       button_level,
  output logic       button_long,
  output logic [2:0] switch_out,
  output logic       switch_changed
);

  localparam logic [31:0] DB_LAST = DEBOUNCE_CYCLES - 32'd1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Two-flop synchronizers; only the second stage feeds the debouncers.
  logic       btn_s1_q, btn_s2_q;
  logic [2:0] sw_s1_q, sw_s2_q;

  // Button debouncer state.
  state_t      state_q, state_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic        pulse_q, pulse_d;
  logic        level_q, level_d;

  // Switch debouncer state.
  logic [2:0]  cand_q, cand_d;
  logic [31:0] scnt_q, scnt_d;
  logic [2:0]  swout_q, swout_d;
  logic        chg_q, chg_d;

  // Synchronizer flops for both raw inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      sw_s1_q  <= 3'b000;
      sw_s2_q  <= 3'b000;
    end else begin
      btn_s1_q <= button_raw;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= switch_raw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Button FSM next-state: a level change is accepted only after
  // DEBOUNCE_CYCLES consecutive agreeing samples; any disagreement restarts.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    case (state_q)
      IDLE: begin
        if (btn_s2_q) begin
          state_d = PRESS_WAIT;
          dcnt_d  = 32'd1;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s2_q) begin
          state_d = IDLE;
          dcnt_d  = 32'd0;
        end else if (dcnt_q == DB_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 32'd1;
        end
      end
      HELD: begin
        if (!btn_s2_q) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = 32'd1;
        end
      end
      RELEASE_WAIT: begin
        // A short low glitch returns to HELD silently; the press continues.
        if (btn_s2_q) begin
          state_d = HELD;
        end else if (dcnt_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = 32'd0;
      end
    endcase
  end

  // Button FSM registers and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dcnt_q  <= 32'd0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

`ifdef INPUT_COND_LONG_PRESS_EN
  logic [31:0] hcnt_q, hcnt_d;
  logic        long_done_q, long_done_d;
  logic        long_q, long_d;
  logic        hold_clr;

  localparam logic [31:0] LP_LAST = LONG_PRESS_CYCLES - 32'd1;

  // Hold timing restarts only on an accepted press, not on a rejected glitch.
  assign hold_clr = (state_q == PRESS_WAIT) && (state_d == HELD);

  // Hold counter: saturates at LP_LAST and fires button_long once per press.
  always_comb begin
    hcnt_d      = hcnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (hold_clr) begin
      hcnt_d = 32'd0;
    end else if (state_q == HELD || state_q == RELEASE_WAIT) begin
      if (hcnt_q == LP_LAST) begin
        if (!long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 32'd1;
      end
    end
    if (state_d == IDLE && state_q != IDLE) begin
      long_done_d = 1'b0;
    end
  end

  // Long-press registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q      <= 32'd0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  assign button_long = long_q;
`else
  assign button_long = 1'b0;
`endif

  // Switch debouncer next-state: the candidate must stay put for the full
  // window; the output only moves (and strobes) if it actually differs.
  always_comb begin
    cand_d  = cand_q;
    scnt_d  = scnt_q;
    swout_d = swout_q;
    chg_d   = 1'b0;
    if (sw_s2_q != cand_q) begin
      cand_d = sw_s2_q;
      scnt_d = 32'd0;
    end else if (scnt_q == DB_LAST) begin
      if (cand_q != swout_q) begin
        swout_d = cand_q;
        chg_d   = 1'b1;
      end
    end else begin
      scnt_d = scnt_q + 32'd1;
    end
  end

  // Switch debouncer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q  <= 3'b000;
      scnt_q  <= 32'd0;
      swout_q <= 3'b000;
      chg_q   <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      scnt_q  <= scnt_d;
      swout_q <= swout_d;
      chg_q   <= chg_d;
    end
  end

  assign button_pulse   = pulse_q;
  assign button_level   = level_q;
  assign switch_out     = swout_q;
  assign switch_changed = chg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=8. Each step drives inputs before an edge and queues the
// outputs expected after that edge; a monitor pops and checks them.
module tb_input_conditioner;

`ifdef INPUT_COND_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       button_raw;
  logic [2:0] switch_raw;
  logic       button_pulse;
  logic       button_level;
  logic       button_long;
  logic [2:0] switch_out;
  logic       switch_changed;

  typedef struct {
    string      tag;
    logic [6:0] v;   // {pulse, level, long, switch_out[2:0], changed}
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES  (32'd4),
    .LONG_PRESS_CYCLES(32'd8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_raw    (button_raw),
    .switch_raw    (switch_raw),
    .button_pulse  (button_pulse),
    .button_level  (button_level),
    .button_long   (button_long),
    .switch_out    (switch_out),
    .switch_changed(switch_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ev(input logic p, input logic l, input logic g,
                                    input logic [2:0] s, input logic c);
    return {p, l, g, s, c};
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input logic b, input logic [2:0] sw, input logic r,
                      input string tag, input logic [6:0] v);
    exp_t e;
    @(negedge clk);
    button_raw = b;
    switch_raw = sw;
    rst        = r;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per edge, checked 1 time unit after the edge.
  always @(posedge clk) begin : mon
    exp_t       e;
    logic [6:0] obs;
    #1;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {button_pulse, button_level, button_long, switch_out, switch_changed};
      tests++;
      assert (obs === e.v) else begin
        fails++;
        $error("FAIL %s: observed %b expected %b (pulse,level,long,sw[2:0],chg)",
               e.tag, obs, e.v);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic b;
    logic [2:0] sw;
    rst        = 1'b1;
    button_raw = 1'b0;
    switch_raw = 3'b000;

    // Reset state.
    repeat (2) step(1'b0, 3'b000, 1'b1, "reset", ev(0, 0, 0, 3'b000, 0));
    for (int k = 0; k < 6; k++) step(1'b0, 3'b000, 1'b0, "idle", ev(0, 0, 0, 3'b000, 0));

    // Clean press held 30 cycles: pulse after E5, level from E5, long after E13.
    for (int k = 0; k < 30; k++)
      step(1'b1, 3'b000, 1'b0, "clean_press",
           ev(k == 5, k >= 5, LONG_EN && (k == 13), 3'b000, 0));
    // Full release: level drops after 5 edges.
    for (int k = 0; k < 8; k++)
      step(1'b0, 3'b000, 1'b0, "release1", ev(0, k < 5, 0, 3'b000, 0));

    // Press bounce 1,0,1,0 then stable: timing restarts from the stable edge (k=4).
    for (int k = 0; k < 20; k++) begin
      b = (k < 4) ? ((k % 2) == 0) : 1'b1;
      step(b, 3'b000, 1'b0, "press_bounce",
           ev(k == 9, k >= 9, LONG_EN && (k == 17), 3'b000, 0));
    end
    // Release glitch of 2 cycles while held: no change, no new pulse, no new long.
    for (int k = 0; k < 8; k++) begin
      b = (k >= 2);
      step(b, 3'b000, 1'b0, "release_glitch", ev(0, 1, 0, 3'b000, 0));
    end
    for (int k = 0; k < 8; k++)
      step(1'b0, 3'b000, 1'b0, "release2", ev(0, k < 5, 0, 3'b000, 0));

    // Switch 000 -> 101: output and strobe after E6.
    for (int k = 0; k < 10; k++)
      step(1'b0, 3'b101, 1'b0, "sw_change",
           ev(0, 0, 0, (k >= 6) ? 3'b101 : 3'b000, k == 6));
    // 111 for two cycles then back to 101: no strobe.
    for (int k = 0; k < 10; k++) begin
      sw = (k < 2) ? 3'b111 : 3'b101;
      step(1'b0, sw, 1'b0, "sw_glitch", ev(0, 0, 0, 3'b101, 0));
    end
    // Move to 011 ahead of the reset scenario.
    for (int k = 0; k < 8; k++)
      step(1'b0, 3'b011, 1'b0, "sw_011",
           ev(0, 0, 0, (k >= 6) ? 3'b011 : 3'b101, k == 6));

    // Reset during PRESS_WAIT: everything clears, no pulse.
    for (int k = 0; k < 3; k++)
      step(1'b1, 3'b011, 1'b0, "pre_rst", ev(0, 0, 0, 3'b011, 0));
    step(1'b1, 3'b011, 1'b1, "mid_rst", ev(0, 0, 0, 3'b000, 0));
    // Switches held at 011 across reset exit: switch_changed fires again.
    for (int k = 0; k < 10; k++)
      step(1'b0, 3'b011, 1'b0, "post_rst",
           ev(0, 0, 0, (k >= 6) ? 3'b011 : 3'b000, k == 6));

    repeat (2) @(posedge clk);
    #2;
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain: observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
